// File: rtl/dts_pkg.sv
// Shared constants for the DTS result checker: error codes, FSM states, width helper.
package dts_pkg;

   localparam logic [1:0] ERR_OK    = 2'd0;
   localparam logic [1:0] ERR_COLL  = 2'd1;
   localparam logic [1:0] ERR_COUNT = 2'd2;
   localparam logic [1:0] ERR_ZERO  = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } state_t;

   // Bits needed to hold a mark position 0..m.
   function automatic int span_w(input int m);
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/dts_diff_mask.sv
// Differences from mark idx to every later mark of one ruler: bit d set means a mark at idx+d.
// Purely combinational; bit 0 (the mark itself) is always cleared.
module dts_diff_mask
   import dts_pkg::*;
#(
   parameter int M = 19
)
(
   input  logic [M:0]           row_bits,
   input  logic [span_w(M)-1:0] idx,
   output logic [M:0]           diffs
);

   always_comb begin
      diffs    = row_bits >> idx;
      diffs[0] = 1'b0;
   end

endmodule

// File: rtl/dts_result_checker.sv
// Captures res on a doneSig rise and checks it is a valid DTS; result pulses n*(M+1)+1 edges after capture.
// No backpressure: a doneSig rise while busy is dropped, and a held-high doneSig triggers only once.
module dts_result_checker
   import dts_pkg::*;
#(
   parameter int n = 3,
   parameter int M = 19,
   parameter int K = 4
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [n*(M+1)-1:0]     res,
   input  logic                   doneSig,
   output logic                   busy,
   output logic                   chk_valid,
   output logic                   chk_pass,
   output logic [1:0]             chk_err,
   output logic [span_w(M)-1:0]   chk_span
);

   localparam int SW = span_w(M);
   localparam int RW = (n > 1) ? $clog2(n) : 1;
   localparam int CW = $clog2(M + 2);

   state_t              state;
   logic                done_q;
   logic [n*(M+1)-1:0]  cap;
   logic [M:0]          used;
   logic [RW-1:0]       row;
   logic [SW-1:0]       idx;
   logic [CW-1:0]       cnt;
   logic [SW-1:0]       span;
   logic [1:0]          err;

   logic [M:0]          row_bits;
   logic [M:0]          diffs;
   logic                b;
   logic                last_i;
   logic                last_row;
   logic [CW-1:0]       cnt_fin;
   logic [1:0]          step_err;

   assign row_bits = cap[row*(M+1) +: M+1];
   assign b        = row_bits[idx];
   assign last_i   = (idx == SW'(M));
   assign last_row = (row == RW'(n - 1));
   assign cnt_fin  = cnt + {{(CW-1){1'b0}}, b};

   dts_diff_mask #(.M(M)) u_diff_mask (
      .row_bits (row_bits),
      .idx      (idx),
      .diffs    (diffs)
   );

   // Later assignments win, giving zero > count > collision for this step.
   always_comb begin
      step_err = ERR_OK;
      if (b && |(diffs & used))
         step_err = ERR_COLL;
      if (last_i && cnt_fin != CW'(K + 1))
         step_err = ERR_COUNT;
      if (idx == '0 && !b)
         step_err = ERR_ZERO;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         done_q    <= 1'b0;
         cap       <= '0;
         used      <= '0;
         row       <= '0;
         idx       <= '0;
         cnt       <= '0;
         span      <= '0;
         err       <= ERR_OK;
         busy      <= 1'b0;
         chk_valid <= 1'b0;
         chk_pass  <= 1'b0;
         chk_err   <= ERR_OK;
         chk_span  <= '0;
      end else begin
         done_q    <= doneSig;
         chk_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (doneSig && !done_q) begin
                  cap   <= res;
                  used  <= '0;
                  row   <= '0;
                  idx   <= '0;
                  cnt   <= '0;
                  span  <= '0;
                  err   <= ERR_OK;
                  busy  <= 1'b1;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (b) begin
                  used <= used | diffs;
                  if (idx > span)
                     span <= idx;
               end
               // Error codes are ordered by priority, so the larger code wins.
               if (step_err > err)
                  err <= step_err;
               if (last_i) begin
                  cnt <= '0;
                  idx <= '0;
                  if (last_row)
                     state <= REPORT;
                  else
                     row <= row + 1'b1;
               end else begin
                  cnt <= cnt_fin;
                  idx <= idx + 1'b1;
               end
            end
            REPORT: begin
               chk_valid <= 1'b1;
               chk_pass  <= (err == ERR_OK);
               chk_err   <= err;
               chk_span  <= span;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dts_result_checker.sv
// Directed bench for dts_result_checker at three parameter sets (n/M/K = 1/6/3, 2/9/2, 3/19/4).
module tb_dts_result_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [6:0]  res_a;
   logic        done_a, busy_a, vld_a, pass_a;
   logic [1:0]  err_a;
   logic [2:0]  span_a;

   logic [19:0] res_b;
   logic        done_b, busy_b, vld_b, pass_b;
   logic [1:0]  err_b;
   logic [3:0]  span_b;

   logic [59:0] res_c;
   logic        done_c, busy_c, vld_c, pass_c;
   logic [1:0]  err_c;
   logic [4:0]  span_c;

   int tests = 0;
   int fails = 0;

   localparam logic [59:0] C_ZERO  = {20'h0C411, 20'h42224, 20'h0008B};
   localparam logic [59:0] C_COUNT = {20'h0C411, 20'h81105, 20'h0008B};

   dts_result_checker #(.n(1), .M(6), .K(3)) dut_a (
      .clk(clk), .reset(rst_n), .res(res_a), .doneSig(done_a), .busy(busy_a),
      .chk_valid(vld_a), .chk_pass(pass_a), .chk_err(err_a), .chk_span(span_a)
   );

   dts_result_checker #(.n(2), .M(9), .K(2)) dut_b (
      .clk(clk), .reset(rst_n), .res(res_b), .doneSig(done_b), .busy(busy_b),
      .chk_valid(vld_b), .chk_pass(pass_b), .chk_err(err_b), .chk_span(span_b)
   );

   dts_result_checker dut_c (
      .clk(clk), .reset(rst_n), .res(res_c), .doneSig(done_c), .busy(busy_c),
      .chk_valid(vld_c), .chk_pass(pass_c), .chk_err(err_c), .chk_span(span_c)
   );

   task automatic run_a(input logic [6:0] r, output int edges);
      res_a = r;
      @(posedge clk); #1 done_a = 1'b1;
      @(posedge clk); #1 done_a = 1'b0;
      edges = 1;
      while (edges < 300) begin
         @(posedge clk); #1;
         edges++;
         if (vld_a) break;
      end
   endtask

   task automatic run_b(input logic [19:0] r, output int edges);
      res_b = r;
      @(posedge clk); #1 done_b = 1'b1;
      @(posedge clk); #1 done_b = 1'b0;
      edges = 1;
      while (edges < 300) begin
         @(posedge clk); #1;
         edges++;
         if (vld_b) break;
      end
   endtask

   task automatic run_c(input logic [59:0] r, output int edges);
      res_c = r;
      @(posedge clk); #1 done_c = 1'b1;
      @(posedge clk); #1 done_c = 1'b0;
      edges = 1;
      while (edges < 300) begin
         @(posedge clk); #1;
         edges++;
         if (vld_c) break;
      end
   endtask

   // edges above counts the capture edge itself, so expected = n*(M+1)+2.
   task automatic test_reset();
      rst_n = 1'b0;
      done_a = 1'b0; done_b = 1'b0; done_c = 1'b0;
      res_a = '0; res_b = '0; res_c = '0;
      #12;
      tests++; if (busy_c !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_c); end
      tests++; if (vld_c !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", vld_c); end
      tests++; if (pass_c !== 1'b0) begin fails++; $display("FAIL reset_pass: got %b want 0", pass_c); end
      tests++; if (err_c !== 2'd0) begin fails++; $display("FAIL reset_err: got %0d want 0", err_c); end
      tests++; if (span_c !== 5'd0) begin fails++; $display("FAIL reset_span: got %0d want 0", span_c); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_small_ruler();
      int e;
      run_a(7'b1010011, e);
      tests++; if (e !== 9) begin fails++; $display("FAIL a_ok_latency: got %0d want 8 edges after capture", e - 1); end
      tests++; if (pass_a !== 1'b1) begin fails++; $display("FAIL a_ok_pass: got %b want 1", pass_a); end
      tests++; if (err_a !== 2'd0) begin fails++; $display("FAIL a_ok_err: got %0d want 0", err_a); end
      tests++; if (span_a !== 3'd6) begin fails++; $display("FAIL a_ok_span: got %0d want 6", span_a); end
      @(posedge clk); #1;
      tests++; if (vld_a !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL a_pulse: valid=%b busy=%b want 0/0", vld_a, busy_a); end
      run_a(7'b1000111, e);
      tests++; if (pass_a !== 1'b0) begin fails++; $display("FAIL a_coll_pass: got %b want 0", pass_a); end
      tests++; if (err_a !== 2'd1) begin fails++; $display("FAIL a_coll_err: got %0d want 1", err_a); end
      tests++; if (span_a !== 3'd6) begin fails++; $display("FAIL a_coll_span: got %0d want 6", span_a); end
   endtask

   task automatic test_two_rulers();
      int e;
      run_b({10'h211, 10'h00B}, e);
      tests++; if (e !== 22) begin fails++; $display("FAIL b_ok_latency: got %0d want 21 edges after capture", e - 1); end
      tests++; if (pass_b !== 1'b1 || err_b !== 2'd0) begin fails++; $display("FAIL b_ok: pass=%b err=%0d want 1/0", pass_b, err_b); end
      tests++; if (span_b !== 4'd9) begin fails++; $display("FAIL b_ok_span: got %0d want 9", span_b); end
      run_b({10'h031, 10'h00B}, e);
      tests++; if (pass_b !== 1'b0 || err_b !== 2'd1) begin fails++; $display("FAIL b_coll: pass=%b err=%0d want 0/1", pass_b, err_b); end
      tests++; if (span_b !== 4'd5) begin fails++; $display("FAIL b_coll_span: got %0d want 5", span_b); end
   endtask

   task automatic test_error_priority();
      int e;
      run_c(C_ZERO, e);
      tests++; if (e !== 62) begin fails++; $display("FAIL c_zero_latency: got %0d want 61 edges after capture", e - 1); end
      tests++; if (pass_c !== 1'b0 || err_c !== 2'd3) begin fails++; $display("FAIL c_zero_err: pass=%b err=%0d want 0/3", pass_c, err_c); end
      tests++; if (span_c !== 5'd18) begin fails++; $display("FAIL c_zero_span: got %0d want 18", span_c); end
      run_c(C_COUNT, e);
      tests++; if (e !== 62) begin fails++; $display("FAIL c_count_latency: got %0d want 61 edges after capture", e - 1); end
      tests++; if (pass_c !== 1'b0 || err_c !== 2'd2) begin fails++; $display("FAIL c_count_err: pass=%b err=%0d want 0/2", pass_c, err_c); end
      tests++; if (span_c !== 5'd19) begin fails++; $display("FAIL c_count_span: got %0d want 19", span_c); end
      run_c('0, e);
      tests++; if (err_c !== 2'd3 || span_c !== 5'd0) begin fails++; $display("FAIL c_empty: err=%0d span=%0d want 3/0", err_c, span_c); end
   endtask

   task automatic test_reset_mid_scan();
      int e;
      int seen;
      res_c = C_COUNT;
      @(posedge clk); #1 done_c = 1'b1;
      @(posedge clk); #1 done_c = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      tests++; if (busy_c !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b want 1", busy_c); end
      rst_n = 1'b0;
      #1;
      tests++; if (busy_c !== 1'b0 || vld_c !== 1'b0) begin fails++; $display("FAIL mid_abort: busy=%b valid=%b want 0/0", busy_c, vld_c); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      seen = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (vld_c) seen++;
      end
      tests++; if (seen !== 0) begin fails++; $display("FAIL mid_no_result: got %0d pulses want 0", seen); end
      run_c(C_COUNT, e);
      tests++; if (e !== 62 || err_c !== 2'd2) begin fails++; $display("FAIL mid_rerun: edges=%0d err=%0d want 61/2", e - 1, err_c); end
   endtask

   task automatic test_no_retrigger();
      int seen;
      res_c = C_COUNT;
      @(posedge clk); #1 done_c = 1'b1;
      seen = 0;
      repeat (200) begin
         @(posedge clk); #1;
         if (vld_c) seen++;
      end
      done_c = 1'b0;
      tests++; if (seen !== 1) begin fails++; $display("FAIL held_high: got %0d pulses want 1", seen); end
      @(posedge clk); #1 done_c = 1'b1;
      @(posedge clk); #1 done_c = 1'b0;
      repeat (5) @(posedge clk);
      #1 done_c = 1'b1;
      tests++; if (busy_c !== 1'b1) begin fails++; $display("FAIL busy_during_scan: got %b want 1", busy_c); end
      @(posedge clk); #1 done_c = 1'b0;
      seen = 0;
      repeat (120) begin
         @(posedge clk); #1;
         if (vld_c) seen++;
      end
      tests++; if (seen !== 1) begin fails++; $display("FAIL rise_while_busy: got %0d pulses want 1", seen); end
      tests++; if (busy_c !== 1'b0) begin fails++; $display("FAIL busy_after: got %b want 0", busy_c); end
   endtask

   initial begin
      test_reset();
      test_small_ruler();
      test_two_rulers();
      test_error_priority();
      test_reset_mid_scan();
      test_no_retrigger();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
